// File: rtl/io_pkg.sv
// Shared types and defaults for the IN-instruction input responder.
package io_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARM,
    S_WAIT_PRESS,
    S_ACK,
    S_DONE
  } state_t;

  // 10 ms at 50 MHz
  localparam int unsigned DEBOUNCE_CYCLES_DEF = 500000;

endpackage

// File: rtl/modulo_entrada_debounce_sync.sv
// Push-button conditioner: 2-flop synchronizer, polarity normalisation,
// stability counter and a one-cycle pulse on each debounced press.
module debounce_sync #(
  parameter int unsigned DEBOUNCE_CYCLES   = 500000,
  parameter bit          BUTTON_ACTIVE_LOW = 1'b1
) (
  input  logic clock,
  input  logic reset_n,
  input  logic button_in,
  output logic debounced,
  output logic press_evt
);

  localparam int unsigned     CNT_W    = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  // Raw pin level that means "not pressed"
  localparam logic            RELEASED_RAW = BUTTON_ACTIVE_LOW;

  logic             r_meta;
  logic             r_sync;
  logic             r_level;
  logic             r_press;
  logic [CNT_W-1:0] r_cnt;
  logic             w_pressed;

  assign w_pressed = r_sync ^ BUTTON_ACTIVE_LOW;
  assign debounced = r_level;
  assign press_evt = r_press;

  // Synchronize the pin, then accept a level change only after it has been
  // stable for DEBOUNCE_CYCLES consecutive samples.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_meta  <= RELEASED_RAW;
      r_sync  <= RELEASED_RAW;
      r_cnt   <= '0;
      r_level <= 1'b0;
      r_press <= 1'b0;
    end else begin
      r_meta  <= button_in;
      r_sync  <= r_meta;
      r_press <= 1'b0;
      if (w_pressed == r_level) begin
        r_cnt <= '0;
      end else if (r_cnt == CNT_LAST) begin
        r_cnt   <= '0;
        r_level <= w_pressed;
        // Pulse coincides with the first cycle the debounced level reads pressed
        r_press <= w_pressed;
      end else begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/modulo_entrada.sv
// IN-instruction responder: on a CPU request, waits for a fresh debounced
// button press, captures the synchronized switch word and returns it with a
// one-cycle data_valid pulse.
module modulo_entrada
  import io_pkg::*;
#(
  parameter int unsigned DATA_W            = 18,
  parameter int unsigned OUT_W             = 32,
  parameter int unsigned DEBOUNCE_CYCLES   = DEBOUNCE_CYCLES_DEF,
  parameter bit          BUTTON_ACTIVE_LOW = 1'b1
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              button_in,
  input  logic [DATA_W-1:0] switches,
  input  logic              op_in,
  output logic [OUT_W-1:0]  data_out,
  output logic              data_valid,
  output logic              waiting
);

  logic [DATA_W-1:0] r_sw_meta;
  logic [DATA_W-1:0] r_sw_sync;
  logic [OUT_W-1:0]  r_data;
  state_t            r_state;
  state_t            w_next;
  logic              w_capture;
  logic              w_debounced;
  logic              w_press_evt;

  debounce_sync #(
    .DEBOUNCE_CYCLES   (DEBOUNCE_CYCLES),
    .BUTTON_ACTIVE_LOW (BUTTON_ACTIVE_LOW)
  ) u_deb (
    .clock     (clock),
    .reset_n   (reset_n),
    .button_in (button_in),
    .debounced (w_debounced),
    .press_evt (w_press_evt)
  );

  assign data_out = r_data;

  // Two-flop synchronizer for the slide switches
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_sw_meta <= '0;
      r_sw_sync <= '0;
    end else begin
      r_sw_meta <= switches;
      r_sw_sync <= r_sw_meta;
    end
  end

  // State register and captured word
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
      r_data  <= '0;
    end else begin
      r_state <= w_next;
      if (w_capture) r_data <= OUT_W'(r_sw_sync);
    end
  end

  // Handshake sequencing; a dropped request always takes priority over a press
  always_comb begin
    w_next     = r_state;
    w_capture  = 1'b0;
    data_valid = 1'b0;
    waiting    = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (op_in) w_next = S_ARM;
      end
      S_ARM: begin
        waiting = 1'b1;
        if (!op_in)            w_next = S_IDLE;
        else if (!w_debounced) w_next = S_WAIT_PRESS;
      end
      S_WAIT_PRESS: begin
        waiting = 1'b1;
        if (!op_in) begin
          w_next = S_IDLE;
        end else if (w_press_evt) begin
          w_capture = 1'b1;
          w_next    = S_ACK;
        end
      end
      S_ACK: begin
        data_valid = 1'b1;
        w_next     = S_DONE;
      end
      S_DONE: begin
        if (!op_in) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_modulo_entrada.sv
// Scoreboard bench for modulo_entrada with a short debounce window.
module tb_modulo_entrada;
  import io_pkg::*;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        button_in;
  logic [17:0] switches;
  logic        op_in;
  logic [31:0] data_out;
  logic        data_valid;
  logic        waiting;

  int unsigned n_pass = 0;
  int unsigned n_total = 0;
  int unsigned pulse_cnt = 0;
  logic [31:0] exp_q[$];

  modulo_entrada #(
    .DATA_W            (18),
    .OUT_W             (32),
    .DEBOUNCE_CYCLES   (4),
    .BUTTON_ACTIVE_LOW (1'b1)
  ) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .button_in  (button_in),
    .switches   (switches),
    .op_in      (op_in),
    .data_out   (data_out),
    .data_valid (data_valid),
    .waiting    (waiting)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  // Every data_valid pulse must match the oldest outstanding expectation
  always @(negedge clock) begin
    if (data_valid === 1'b1) begin
      pulse_cnt++;
      if (exp_q.size() == 0) chk("unexpected_valid", data_out, 32'hFFFF_FFFF);
      else chk("data_out", data_out, exp_q.pop_front());
    end
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic press_release(input logic [17:0] sw);
    switches  = sw;
    button_in = 1'b0;
    cyc(10);
    button_in = 1'b1;
    cyc(10);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int lat;
    bit found;
    reset_n = 1'b0; op_in = 1'b0; button_in = 1'b1; switches = '0;

    // 1: reset, then a clean press
    cyc(2);
    @(negedge clock);
    chk("rst_data_out", data_out, 32'h0);
    chk("rst_valid", {31'b0, data_valid}, 32'h0);
    chk("rst_waiting", {31'b0, waiting}, 32'h0);
    reset_n = 1'b1;
    cyc(2);
    pulse_cnt = 0;
    switches = 18'h2A5A5; op_in = 1'b1;
    cyc(3);
    @(negedge clock);
    chk("s1_waiting", {31'b0, waiting}, 32'h1);
    exp_q.push_back(32'h0002A5A5);
    press_release(18'h2A5A5);
    chk("s1_pulses", pulse_cnt, 1);
    chk("s1_done_waiting", {31'b0, waiting}, 32'h0);
    op_in = 1'b0;
    cyc(2);

    // 2: bouncing button
    pulse_cnt = 0;
    op_in = 1'b1; switches = 18'h15555;
    cyc(3);
    exp_q.push_back(32'h00015555);
    for (int i = 0; i < 6; i++) begin
      button_in = i[0];
      cyc(1);
    end
    // bouncing has reached the debouncer by now, still nothing accepted
    button_in = 1'b1;
    cyc(2);
    chk("s2_no_pulse_bounce", pulse_cnt, 0);
    button_in = 1'b0;
    lat = 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clock);
      if (data_valid === 1'b1) begin lat = i; break; end
    end
    chk("s2_latency_ok", {31'b0, (lat >= 6 && lat <= 8)}, 32'h1);
    cyc(8);
    button_in = 1'b1;
    cyc(10);
    chk("s2_pulses", pulse_cnt, 1);
    op_in = 1'b0;
    cyc(2);

    // 3: press held from before the request is not accepted
    pulse_cnt = 0;
    button_in = 1'b0;
    cyc(10);
    op_in = 1'b1;
    cyc(20);
    chk("s3_no_capture", pulse_cnt, 0);
    chk("s3_waiting", {31'b0, waiting}, 32'h1);
    button_in = 1'b1;
    cyc(10);
    exp_q.push_back(32'h00000003);
    press_release(18'h00003);
    chk("s3_pulses", pulse_cnt, 1);
    op_in = 1'b0;
    cyc(2);

    // 4: held op_in never retriggers; back-to-back request works
    pulse_cnt = 0;
    op_in = 1'b1;
    cyc(3);
    exp_q.push_back(32'h00000111);
    press_release(18'h00111);
    switches = 18'h02222;
    button_in = 1'b0;
    cyc(10);
    button_in = 1'b1;
    cyc(30);
    @(negedge clock);
    chk("s4_single_pulse", pulse_cnt, 1);
    chk("s4_data_hold", data_out, 32'h00000111);
    chk("s4_done_waiting", {31'b0, waiting}, 32'h0);
    op_in = 1'b0;
    cyc(1);
    pulse_cnt = 0;
    op_in = 1'b1;
    cyc(3);
    exp_q.push_back(32'h0003FFFF);
    press_release(18'h3FFFF);
    chk("s4_second_pulse", pulse_cnt, 1);
    op_in = 1'b0;
    cyc(2);

    // 5: request dropped on the very cycle the press is recognised
    pulse_cnt = 0;
    op_in = 1'b1;
    cyc(3);
    switches = 18'h01234;
    button_in = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clock);
      if (dut.w_press_evt === 1'b1) begin found = 1'b1; break; end
    end
    op_in = 1'b0;
    chk("s5_press_seen", {31'b0, found}, 32'h1);
    cyc(3);
    @(negedge clock);
    chk("s5_no_pulse", pulse_cnt, 0);
    chk("s5_data_kept", data_out, 32'h0003FFFF);
    chk("s5_idle", {29'b0, dut.r_state}, {29'b0, S_IDLE});
    button_in = 1'b1;
    cyc(10);

    // 6a: reset while waiting for a press
    op_in = 1'b1;
    cyc(4);
    reset_n = 1'b0;
    cyc(1);
    @(negedge clock);
    chk("s6a_valid", {31'b0, data_valid}, 32'h0);
    chk("s6a_waiting", {31'b0, waiting}, 32'h0);
    chk("s6a_data", data_out, 32'h0);
    reset_n = 1'b1; op_in = 1'b0;
    cyc(2);

    // 6b: reset during the acknowledge cycle
    pulse_cnt = 0;
    op_in = 1'b1; switches = 18'h0ABCD;
    cyc(4);
    exp_q.push_back(32'h0000ABCD);
    button_in = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clock);
      if (data_valid === 1'b1) begin found = 1'b1; break; end
    end
    #1;
    reset_n = 1'b0;
    chk("s6b_ack_seen", {31'b0, found}, 32'h1);
    @(negedge clock);
    chk("s6b_valid", {31'b0, data_valid}, 32'h0);
    chk("s6b_waiting", {31'b0, waiting}, 32'h0);
    chk("s6b_data", data_out, 32'h0);
    reset_n = 1'b1; op_in = 1'b0; button_in = 1'b1;
    cyc(12);
    pulse_cnt = 0;
    op_in = 1'b1;
    cyc(3);
    exp_q.push_back(32'h0002A5A5);
    press_release(18'h2A5A5);
    chk("s6_fresh_pulses", pulse_cnt, 1);
    op_in = 1'b0;
    cyc(2);

    chk("sb_empty", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
